ntt_mod_addsub_pipe: RTL and testbench
======================================

Name: ntt_mod_addsub_pipe

Overview:
- Pipelined modular add/subtract stage for the NTT butterfly datapath; sits directly downstream of the 16-bit Brent-Kung adder primitive.
- Consumes two residues a, b < Q.
- Produces (a+b) mod Q and (a-b) mod Q every cycle.
- 2-stage pipeline with valid/ready handshake on both sides; feeds the butterfly output register / coefficient RAM write port.

Parameters:
- WIDTH, 16, coefficient width in bits; must satisfy Q < 2^(WIDTH-1).
- Q, 3329, modulus (Kyber default); compile-time constant.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream operand pair valid.
- ready_o  output  1  block can accept operands this cycle.
- a_i  input  WIDTH  operand a, 0 <= a_i < Q.
- b_i  input  WIDTH  operand b, 0 <= b_i < Q.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- sum_o  output  WIDTH  (a+b) mod Q.
- diff_o  output  WIDTH  (a-b) mod Q.
- err_o  output  1  range error flag (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high. On rst_i=1 at a clock edge:
  - s1_valid=0, s2_valid=0, hence valid_o=0.
  - sum_o=0, diff_o=0, err_o=0.
  - ready_o=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight data; no result for those operands ever appears.
- Transfers: input transfer when valid_i & ready_o; output transfer when valid_o & ready_i.
- Stage 1 (S1), on input transfer:
  - Register raw_sum = a+b (WIDTH+1 bits, carry-in 0).
  - Register raw_diff = a-b (WIDTH+1 bits, two's complement; computed as a + ~b + 1 through the same adder type).
- Stage 2 (S2):
  - sum_o = raw_sum - Q if raw_sum >= Q, else raw_sum.
  - diff_o = raw_diff + Q if raw_diff is negative (bit WIDTH set), else raw_diff.
  - Results registered; valid_o = s2_valid.
- Latency: 2 cycles from input transfer to valid_o when ready_i is held high. Throughput: 1 pair/cycle.
- Flow control:
  - s2_advance = !s2_valid | ready_i.
  - s1_advance = !s1_valid | s2_advance.
  - ready_o = s1_advance (combinational from ready_i; no skid buffer).
- Backpressure:
  - With ready_i=0, S2 holds sum_o/diff_o/valid_o stable.
  - S1 holds once full.
  - ready_o drops only when both stages are full.
  - No loss, no duplication, order preserved.
- Simultaneous input and output transfer in the same cycle: both occur; occupancy unchanged.
- valid_i=1 with ready_o=0: upstream must hold a_i/b_i stable; the block samples nothing.
- Boundaries:
  - a=b=Q-1 gives sum Q-2, diff 0.
  - a=0, b=Q-1 gives diff 1.
  - a+b=Q exactly gives sum 0.
- Operands >= Q are out of contract; outputs for them are undefined unless the checking feature is enabled.

Optional Feature:
- Macro: NTT_MOD_RANGE_CHECK_EN.
- Defined:
  - On every input transfer, if a_i >= Q or b_i >= Q, set err_o=1.
  - err_o is sticky until rst_i.
  - Datapath behaviour is unchanged.
- Not defined: err_o tied to 0 and no comparators are synthesised.

Decomposition:
- Shared package ntt_pkg holds:
  - WIDTH and Q constants.
  - coeff_t, a WIDTH-bit logic type.
  - wide_t, a (WIDTH+1)-bit type for raw sum/diff.
- Sub-module mod_correct: purely combinational conditional subtract/add of Q.
  - Instantiated once for the sum path and once for the diff path.
  - Internal adds use the team's Brent-Kung adder primitive.

Test Plan:
- ready_i=1; send a=3000,b=1000 -> two cycles later valid_o=1, sum_o=671, diff_o=2000.
- a=5,b=10 -> sum_o=15, diff_o=3324. Then a=3328,b=3328 -> sum_o=3327, diff_o=0 on the next cycle; confirms back-to-back throughput.
- a=1664,b=1665 -> sum_o=0. a=0,b=3328 -> diff_o=1.
- Stream 4 pairs with ready_i=0 for cycles 2-5:
  - ready_o falls after 2 accepted pairs.
  - valid_o/sum_o stay stable while stalled.
  - After ready_i=1, all 4 results emerge in order with no drops.
- Pulse rst_i with 2 pairs in flight -> next cycle valid_o=0, sum_o=0, diff_o=0, ready_o=1; no stale result appears afterwards.
- With NTT_MOD_RANGE_CHECK_EN: send a=3329,b=0 -> err_o=1 from the next cycle and stays high through further legal traffic until rst_i.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT modular add/subtract datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// WIDTH is the coefficient width and Q the modulus; Q < 2^(WIDTH-1) keeps
// a+b inside WIDTH bits and a-b inside a signed WIDTH+1-bit value.
package ntt_pkg;

    localparam int WIDTH = 16;
    localparam int Q     = 3329;

    // Reduced coefficient and raw (one guard bit) sum/difference.
    typedef logic [WIDTH-1:0] coeff_t;
    typedef logic [WIDTH:0]   wide_t;

    localparam coeff_t Q_COEFF = coeff_t'(Q);
    localparam wide_t  Q_WIDE  = wide_t'(Q);

    // Direction of the final conditional correction in mod_correct.
    typedef enum logic {
        CORR_SUB_Q = 1'b0,
        CORR_ADD_Q = 1'b1
    } corr_mode_e;

endpackage

// File: rtl/ntt_mod_addsub_pipe_if.sv
// Operand/result handshake bundle for ntt_mod_addsub_pipe.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
//
// Signals: valid_i/ready_o/a_i/b_i form the operand channel, valid_o/ready_i/
// sum_o/diff_o the result channel, err_o the sticky range-error flag.
// The slave modport is the datapath block, master is whatever drives it.
interface ntt_mod_addsub_pipe_if;
    import ntt_pkg::*;

    logic   valid_i;
    logic   ready_o;
    coeff_t a_i;
    coeff_t b_i;
    logic   valid_o;
    logic   ready_i;
    coeff_t sum_o;
    coeff_t diff_o;
    logic   err_o;

    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, sum_o, diff_o, err_o
    );

    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, sum_o, diff_o, err_o
    );

endinterface

// File: rtl/bk_adder.sv
// Brent-Kung parallel-prefix adder primitive, N bits with carry-in.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a, b (N bits), cin; sum (N bits, carry-out dropped - callers size N
// so the carry they care about lands in the top sum bit).
module bk_adder #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    // Largest power of two strictly below N: first span of the down-sweep.
    function automatic int top_pow2(input int n);
        int d;
        d = 1;
        while (d * 2 < n) d = d * 2;
        return d;
    endfunction

    localparam int TOP = top_pow2(N);

    always_comb begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] gg;
        logic [N-1:0] pp;

        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        // Fold the carry-in into bit 0 so gg[i] becomes the carry out of bit i.
        gg[0] = g[0] | (p[0] & cin);

        // Up-sweep: build group (g,p) over power-of-two aligned spans.
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end

        // Down-sweep: fill the remaining prefixes from the completed spans.
        for (int d = TOP; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end

        sum = p ^ {gg[N-2:0], cin};
    end

endmodule

// File: rtl/mod_correct.sv
// Final modular correction: conditional subtract of Q (sum path) or
// conditional add of Q (difference path). Latency: combinational.
// Backpressure: none.
//
// Ports: raw (WIDTH+1-bit raw sum or two's-complement difference),
// res (reduced WIDTH-bit residue). MODE selects the correction direction.
module mod_correct
    import ntt_pkg::*;
#(
    parameter corr_mode_e MODE = CORR_SUB_Q
) (
    input  wide_t  raw,
    output coeff_t res
);

    wide_t addend;
    logic  carry_in;
    wide_t corrected;
    logic  take;

    if (MODE == CORR_SUB_Q) begin : g_sub
        // raw - Q as raw + ~Q + 1. raw < 2Q < 2^WIDTH, so the top bit of the
        // result is set exactly when raw < Q and the subtraction must be dropped.
        assign addend   = ~Q_WIDE;
        assign carry_in = 1'b1;
        assign take     = ~corrected[WIDTH];
    end else begin : g_add
        // A negative difference (sign bit set) lies in [-(Q-1), -1]; adding Q
        // brings it into range and the low WIDTH bits hold the residue.
        assign addend   = Q_WIDE;
        assign carry_in = 1'b0;
        assign take     = raw[WIDTH];
    end

    bk_adder #(
        .N (WIDTH + 1)
    ) u_adder (
        .a   (raw),
        .b   (addend),
        .cin (carry_in),
        .sum (corrected)
    );

    assign res = take ? corrected[WIDTH-1:0] : raw[WIDTH-1:0];

    // Each mode ignores one of the two top bits.
    logic unused_msbs;
    assign unused_msbs = raw[WIDTH] ^ corrected[WIDTH];

endmodule

// File: rtl/ntt_mod_addsub_pipe.sv
// Pipelined modular add/subtract: (a+b) mod Q and (a-b) mod Q per pair.
// Latency: 2 cycles input transfer -> valid_o; 1 pair/cycle throughput.
// Backpressure: ready_o = s1 empty | s2 empty | ready_i (combinational, no skid).
//
// Ports: clk_i (rising edge), rst_i (synchronous, active-high), bus (slave
// modport of ntt_mod_addsub_pipe_if). Width and modulus come from ntt_pkg.
// Optional macro NTT_MOD_RANGE_CHECK_EN: sticky err_o when an accepted operand
// is >= Q; without it err_o is tied low and no comparators exist.
module ntt_mod_addsub_pipe
    import ntt_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    ntt_mod_addsub_pipe_if.slave  bus
);

    logic   s1_valid;
    logic   s2_valid;
    logic   s1_advance;
    logic   s2_advance;
    logic   in_xfer;

    wide_t  raw_sum_d;
    wide_t  raw_diff_d;
    wide_t  raw_sum_q;
    wide_t  raw_diff_q;

    coeff_t sum_d;
    coeff_t diff_d;
    coeff_t sum_q;
    coeff_t diff_q;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_advance = !s2_valid || bus.ready_i;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_xfer    = bus.valid_i && s1_advance;

    assign bus.ready_o = s1_advance;
    assign bus.valid_o = s2_valid;
    assign bus.sum_o   = sum_q;
    assign bus.diff_o  = diff_q;

    // Stage 1 arithmetic: zero-extended a+b and a + ~b + 1.
    bk_adder #(
        .N (WIDTH + 1)
    ) u_add_sum (
        .a   ({1'b0, bus.a_i}),
        .b   ({1'b0, bus.b_i}),
        .cin (1'b0),
        .sum (raw_sum_d)
    );

    bk_adder #(
        .N (WIDTH + 1)
    ) u_add_diff (
        .a   ({1'b0, bus.a_i}),
        .b   (~{1'b0, bus.b_i}),
        .cin (1'b1),
        .sum (raw_diff_d)
    );

    // Stage 2 arithmetic: bring both raw values back into [0, Q).
    mod_correct #(
        .MODE (CORR_SUB_Q)
    ) u_corr_sum (
        .raw (raw_sum_q),
        .res (sum_d)
    );

    mod_correct #(
        .MODE (CORR_ADD_Q)
    ) u_corr_diff (
        .raw (raw_diff_q),
        .res (diff_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            raw_sum_q  <= '0;
            raw_diff_q <= '0;
            sum_q      <= '0;
            diff_q     <= '0;
        end else begin
            if (s1_advance) begin
                s1_valid <= bus.valid_i;
            end
            if (in_xfer) begin
                raw_sum_q  <= raw_sum_d;
                raw_diff_q <= raw_diff_d;
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
                // Results only load from a live S1 so a bubble leaves them untouched.
                if (s1_valid) begin
                    sum_q  <= sum_d;
                    diff_q <= diff_d;
                end
            end
        end
    end

`ifdef NTT_MOD_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (in_xfer && ((bus.a_i >= Q_COEFF) || (bus.b_i >= Q_COEFF))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_mod_addsub_pipe.sv
// Bench for ntt_mod_addsub_pipe: directed vector table, backpressure and
// reset sequences, range-flag behaviour and a randomized stream checked
// against a plain-arithmetic modular model with an in-order expected queue.
module tb_ntt_mod_addsub_pipe;
    import ntt_pkg::*;

`ifdef NTT_MOD_RANGE_CHECK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ntt_mod_addsub_pipe_if bus();

    ntt_mod_addsub_pipe dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int a;
        int b;
        int s;
        int d;
    } vec_t;

    typedef struct {
        logic care;
        int   s;
        int   d;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    logic prev_stall = 1'b0;
    logic err_seen = 1'b0;

    function automatic int ref_sum(input int a, input int b);
        return (a + b) % Q;
    endfunction

    function automatic int ref_diff(input int a, input int b);
        return (a - b + Q) % Q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle of traffic: drive on the falling edge, sample 1 time
    // unit later, score the result transfer, log the operand transfer.
    task automatic step(input logic v, input int a, input int b, input logic rdy,
                        input logic care, output logic acc, output logic rdy_seen);
        exp_t e;
        @(negedge clk);
        bus.valid_i = v;
        bus.a_i     = coeff_t'(a);
        bus.b_i     = coeff_t'(b);
        bus.ready_i = rdy;
        #1;
        rdy_seen = bus.ready_o;
        acc      = v && bus.ready_o;
        err_seen = bus.err_o;
        // Only a completely full pipeline with a stalled output may refuse.
        check("ready_o", int'(bus.ready_o), int'((exp_q.size() < 2) || rdy));
        if (prev_stall) begin
            check("stall_valid_held", int'(bus.valid_o), 1);
        end
        if (bus.valid_o && exp_q.size() > 0 && exp_q[0].care) begin
            check("out_sum", int'(bus.sum_o), exp_q[0].s);
            check("out_diff", int'(bus.diff_o), exp_q[0].d);
        end
        if (bus.valid_o && rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got sum %0d diff %0d, expected no result",
                         bus.sum_o, bus.diff_o);
            end else begin
                e = exp_q.pop_front();
                n_out++;
            end
        end
        prev_stall = bus.valid_o && !rdy;
        if (acc) begin
            e.care = care;
            e.s    = ref_sum(a, b);
            e.d    = ref_diff(a, b);
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        #1;
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_sum_o", int'(bus.sum_o), 0);
        check("rst_diff_o", int'(bus.diff_o), 0);
        check("rst_ready_o", int'(bus.ready_o), 1);
        check("rst_err_o", int'(bus.err_o), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic rs;
        logic hold;
        logic v;
        logic r;
        int   p;
        int   n0;
        int   a;
        int   b;
        int   pa[4];
        int   pb[4];

        bus.valid_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.ready_i = 1'b0;

        repeat (2) @(posedge clk);
        do_reset();

        // Directed table, issued back to back with ready_i held high.
        vecs.push_back('{a: 3000, b: 1000, s: 671,  d: 2000});
        vecs.push_back('{a: 5,    b: 10,   s: 15,   d: 3324});
        vecs.push_back('{a: 3328, b: 3328, s: 3327, d: 0});
        vecs.push_back('{a: 1664, b: 1665, s: 0,    d: 3328});
        vecs.push_back('{a: 0,    b: 3328, s: 3328, d: 1});
        vecs.push_back('{a: 0,    b: 0,    s: 0,    d: 0});
        vecs.push_back('{a: 1,    b: 3328, s: 0,    d: 2});
        vecs.push_back('{a: 3328, b: 0,    s: 3328, d: 3328});
        vecs.push_back('{a: 2000, b: 1500, s: 171,  d: 500});
        vecs.push_back('{a: 1234, b: 1234, s: 2468, d: 0});

        for (int i = 0; i < vecs.size() + 2; i++) begin
            @(negedge clk);
            bus.ready_i = 1'b1;
            if (i < vecs.size()) begin
                bus.valid_i = 1'b1;
                bus.a_i     = coeff_t'(vecs[i].a);
                bus.b_i     = coeff_t'(vecs[i].b);
            end else begin
                bus.valid_i = 1'b0;
            end
            #1;
            if (i == 1) begin
                check("tbl_latency_not_1", int'(bus.valid_o), 0);
            end
            if (i >= 2) begin
                check($sformatf("tbl_valid[%0d]", i - 2), int'(bus.valid_o), 1);
                check($sformatf("tbl_sum[%0d]", i - 2), int'(bus.sum_o), vecs[i - 2].s);
                check($sformatf("tbl_diff[%0d]", i - 2), int'(bus.diff_o), vecs[i - 2].d);
            end
        end
        step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);

        // Backpressure: four pairs, output stalled for cycles 2..5.
        pa = '{100, 3328, 2500, 7};
        pb = '{200, 1, 2500, 3000};
        p  = 0;
        n0 = n_out;
        for (int cyc = 0; cyc < 30 && (p < 4 || exp_q.size() > 0); cyc++) begin
            r = !(cyc >= 2 && cyc <= 5);
            if (p < 4) begin
                step(1'b1, pa[p], pb[p], r, 1'b1, acc, rs);
            end else begin
                step(1'b0, 0, 0, r, 1'b1, acc, rs);
            end
            if (cyc == 2) begin
                check("bp_accepted_before_stall", p, 2);
                check("bp_ready_low", int'(rs), 0);
            end
            if (acc) p++;
        end
        check("bp_all_results_out", n_out - n0, 4);

        // Reset with two pairs in flight: nothing from them may surface.
        step(1'b1, 11, 22, 1'b0, 1'b1, acc, rs);
        step(1'b1, 33, 44, 1'b0, 1'b1, acc, rs);
        check("rst_inflight_occupancy", exp_q.size(), 2);
        do_reset();
        n0 = n_out;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);
        end
        check("rst_no_stale_result", n_out - n0, 0);

        // Range flag: out-of-range a, then legal traffic; sticky until reset.
        step(1'b1, Q, 0, 1'b1, 1'b0, acc, rs);
        check("err_before_bad_xfer", int'(err_seen), 0);
        step(1'b1, 1000, 2000, 1'b1, 1'b1, acc, rs);
        check("err_after_bad_a", int'(err_seen), ERR_EN);
        step(1'b1, 3328, 1, 1'b1, 1'b1, acc, rs);
        check("err_sticky_1", int'(err_seen), ERR_EN);
        step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);
        check("err_sticky_2", int'(err_seen), ERR_EN);
        step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);
        do_reset();
        step(1'b1, 5, Q + 100, 1'b1, 1'b0, acc, rs);
        step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);
        check("err_after_bad_b", int'(err_seen), ERR_EN);
        step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);
        do_reset();

        // Randomized stream; a refused pair is held stable until accepted.
        hold = 1'b0;
        v    = 1'b0;
        a    = 0;
        b    = 0;
        for (int k = 0; k < 600; k++) begin
            if (!hold) begin
                v = ($urandom_range(99) < 70);
                a = ($urandom_range(3) == 0) ? Q - 1 : int'($urandom_range(Q - 1));
                b = ($urandom_range(3) == 0) ? Q - 1 : int'($urandom_range(Q - 1));
            end
            r = ($urandom_range(99) < 65);
            step(v, a, b, r, 1'b1, acc, rs);
            hold = v && !acc;
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            step(1'b0, 0, 0, 1'b1, 1'b1, acc, rs);
        end
        check("rand_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
